// File: rtl/inst_queue_if.sv
`default_nettype none
// ============================================================================
// Module      : inst_queue_if
// Description : Fetch-side and decode-side signal bundle of the instruction
//               queue. The queue uses the slave modport; the fetch/decode
//               side (or a testbench) uses the master modport.
//   flush            redirect: discard all queued entries
//   in_valid/ready   fetch packet handshake
//   in_inst[63:0]    {inst at in_pc+4, inst at in_pc}
//   in_pc            PC of the low word
//   in_mask[1:0]     lane enables (bit0 low word, bit1 high word)
//   out_valid[1:0]   thermometer valid of the two oldest entries
//   out_inst0/pc0    oldest entry
//   out_inst1/pc1    second-oldest entry
//   out_pop[1:0]     entries consumed this cycle
// Revision    : 1.0 - initial release
// ============================================================================
interface inst_queue_if #(
  parameter int PC_W = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [63:0]     in_inst;
  logic [PC_W-1:0] in_pc;
  logic [1:0]      in_mask;
  logic [1:0]      out_valid;
  logic [31:0]     out_inst0;
  logic [PC_W-1:0] out_pc0;
  logic [31:0]     out_inst1;
  logic [PC_W-1:0] out_pc1;
  logic [1:0]      out_pop;

  modport master (
    output flush, in_valid, in_inst, in_pc, in_mask, out_pop,
    input  in_ready, out_valid, out_inst0, out_pc0, out_inst1, out_pc1
  );

  modport slave (
    input  flush, in_valid, in_inst, in_pc, in_mask, out_pop,
    output in_ready, out_valid, out_inst0, out_pc0, out_inst1, out_pc1
  );
endinterface
`default_nettype wire

// File: rtl/inst_queue.sv
`default_nettype none
// ============================================================================
// Module      : inst_queue
// Description : Dual-issue instruction queue. Accepts fetch packets of up to
//               two instructions, stores them in program order with their PCs
//               in a DEPTH-entry circular buffer, and presents the two oldest
//               entries to decode. Decode retires 0..2 entries per cycle;
//               flush empties the queue.
// Ports       : clk  - clock, rising edge
//               rst  - asynchronous reset, active-low
//               bus  - inst_queue_if.slave (fetch input, decode output)
// Options     : INST_QUEUE_BYPASS_EN - when defined, a packet accepted into
//               an empty queue is presented on the outputs in the same cycle;
//               lanes popped in that cycle are never written to storage.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_queue #(
  parameter int DEPTH = 8,
  parameter int PC_W  = 32
) (
  input  wire           clk,
  input  wire           rst,
  inst_queue_if.slave   bus
);
  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;

  logic [31:0]     r_inst [DEPTH];
  logic [PC_W-1:0] r_pc   [DEPTH];
  logic [c_aw-1:0] r_rd_ptr;
  logic [c_aw-1:0] r_wr_ptr;
  logic [c_cw-1:0] r_count;

  logic [31:0]     w_lane0_inst, w_lane1_inst;
  logic [PC_W-1:0] w_lane0_pc, w_lane1_pc;
  logic [1:0]      w_push_n;
  logic            w_accept;
  logic            w_ready;
  logic            w_byp;
  logic [c_aw-1:0] w_rd1;
  logic [1:0]      w_valid;
  logic [31:0]     w_o_inst0, w_o_inst1;
  logic [PC_W-1:0] w_o_pc0, w_o_pc1;
  logic [1:0]      w_nvalid;
  logic [1:0]      w_eff_pop;
  logic [1:0]      w_pop_q;
  logic [1:0]      w_skip;
  logic [1:0]      w_store_n;
  logic [31:0]     w_wr0_inst;
  logic [PC_W-1:0] w_wr0_pc;

  // rst is active-low, so it doubles as the "out of reset" qualifier here.
  assign w_ready  = rst & ~bus.flush & (r_count <= c_cw'(DEPTH - 2));
  assign w_accept = bus.in_valid & w_ready;
  assign w_rd1    = r_rd_ptr + c_aw'(1);

  // Pack the enabled lanes so the first enabled lane is always lane0.
  always_comb begin
    w_lane0_inst = bus.in_mask[0] ? bus.in_inst[31:0] : bus.in_inst[63:32];
    w_lane0_pc   = bus.in_mask[0] ? bus.in_pc : bus.in_pc + PC_W'(4);
    w_lane1_inst = bus.in_inst[63:32];
    w_lane1_pc   = bus.in_pc + PC_W'(4);
    w_push_n     = {1'b0, bus.in_mask[0]} + {1'b0, bus.in_mask[1]};
  end

`ifdef INST_QUEUE_BYPASS_EN
  // flush already forces w_ready low, so w_accept implies no flush.
  assign w_byp = w_accept & (r_count == '0);
`else
  assign w_byp = 1'b0;
`endif

  always_comb begin
    w_valid   = {r_count >= c_cw'(2), r_count >= c_cw'(1)};
    w_o_inst0 = r_inst[r_rd_ptr];
    w_o_pc0   = r_pc[r_rd_ptr];
    w_o_inst1 = r_inst[w_rd1];
    w_o_pc1   = r_pc[w_rd1];
    if (w_byp) begin
      w_valid   = {w_push_n == 2'd2, 1'b1};
      w_o_inst0 = w_lane0_inst;
      w_o_pc0   = w_lane0_pc;
      w_o_inst1 = w_lane1_inst;
      w_o_pc1   = w_lane1_pc;
    end
    if (!w_valid[0]) begin
      w_o_inst0 = '0;
      w_o_pc0   = '0;
    end
    if (!w_valid[1]) begin
      w_o_inst1 = '0;
      w_o_pc1   = '0;
    end
  end

  // Pop is clamped to what is actually presented; excess is ignored.
  always_comb begin
    w_nvalid  = {1'b0, w_valid[0]} + {1'b0, w_valid[1]};
    w_eff_pop = (bus.out_pop > w_nvalid) ? w_nvalid : bus.out_pop;
    // A bypass pop consumes incoming lanes, not storage.
    w_pop_q   = w_byp ? 2'd0 : w_eff_pop;
    w_skip    = w_byp ? w_eff_pop : 2'd0;
    w_store_n = w_accept ? (w_push_n - w_skip) : 2'd0;
    w_wr0_inst = (w_skip == 2'd0) ? w_lane0_inst : w_lane1_inst;
    w_wr0_pc   = (w_skip == 2'd0) ? w_lane0_pc   : w_lane1_pc;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_inst[i] <= '0;
        r_pc[i]   <= '0;
      end
    end else if (bus.flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_store_n != 2'd0) begin
        r_inst[r_wr_ptr] <= w_wr0_inst;
        r_pc[r_wr_ptr]   <= w_wr0_pc;
      end
      if (w_store_n == 2'd2) begin
        r_inst[r_wr_ptr + c_aw'(1)] <= w_lane1_inst;
        r_pc[r_wr_ptr + c_aw'(1)]   <= w_lane1_pc;
      end
      r_wr_ptr <= r_wr_ptr + c_aw'(w_store_n);
      r_rd_ptr <= r_rd_ptr + c_aw'(w_pop_q);
      r_count  <= r_count + c_cw'(w_store_n) - c_cw'(w_pop_q);
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = w_valid;
  assign bus.out_inst0 = w_o_inst0;
  assign bus.out_pc0   = w_o_pc0;
  assign bus.out_inst1 = w_o_inst1;
  assign bus.out_pc1   = w_o_pc1;
endmodule
`default_nettype wire
